hwag_sync: RTL and testbench

HWAG_SYNC -- requirements
Module: hwag_sync

---
 rtl/hwag_sync.sv | 180 ++++++++++++++++++
 tb/tb_hwag_sync.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/hwag_sync.sv
// Crank-wheel synchroniser: measures tooth periods, finds the missing-tooth gap, tracks position.
// Optional saturating sync-loss counter is built only when HWAG_SYNC_ERRCNT_EN is defined.
module hwag_sync #(
  parameter int unsigned PW = 24,
  parameter int unsigned TW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          tooth_edge,
  input  logic [TW-1:0] tooth_num,
  input  logic [1:0]    miss_num,
  output logic          sync,
  output logic [TW-1:0] tooth_cnt,
  output logic [PW-1:0] period,
  output logic          gap_pulse,
  output logic          err_pulse,
  output logic [7:0]    err_cnt,
  output logic          stall
);

  typedef enum logic [1:0] {StIdle, StSearch, StSync} state_e;

  localparam logic [PW-1:0] CntMax = '1;

  state_e        state_q, state_d;
  logic [PW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] p0_q, p0_d, p1_q, p1_d, p2_q, p2_d;
  logic [1:0]    vcnt_q, vcnt_d;
  logic          eval_q, eval_d;
  logic          sync_q, sync_d;
  logic [TW-1:0] tooth_cnt_q, tooth_cnt_d;
  logic [PW-1:0] period_q, period_d;
  logic          gap_q, gap_d;
  logic          err_q, err_d;
  logic          stall_q, stall_d;

  logic [TW-1:0] last_idx;
  logic          cnt_sat;
  logic          sat_hit;
  logic          gap_det;

  assign last_idx = tooth_num - TW'(miss_num) - TW'(1);
  assign cnt_sat  = (cnt_q == CntMax);
  // Saturation fires once, on the increment that lands on all-ones; an edge that cycle wins.
  assign sat_hit  = !tooth_edge && (cnt_q == CntMax - PW'(1));
  assign gap_det  = (vcnt_q == 2'd3) &&
                    ({1'b0, p0_q} > {p1_q, 1'b0}) &&
                    ({1'b0, p0_q} > {p2_q, 1'b0});

  always_comb begin
    cnt_d       = cnt_q;
    p0_d        = p0_q;
    p1_d        = p1_q;
    p2_d        = p2_q;
    vcnt_d      = vcnt_q;
    eval_d      = tooth_edge;
    state_d     = state_q;
    tooth_cnt_d = tooth_cnt_q;
    period_d    = period_q;
    gap_d       = 1'b0;
    err_d       = 1'b0;
    stall_d     = stall_q;

    if (tooth_edge) begin
      cnt_d   = PW'(1);
      stall_d = 1'b0;
      if (!cnt_sat) begin
        p2_d   = p1_q;
        p1_d   = p0_q;
        p0_d   = cnt_q;
        vcnt_d = (vcnt_q == 2'd3) ? 2'd3 : vcnt_q + 2'd1;
      end
    end else if (!cnt_sat) begin
      cnt_d = cnt_q + PW'(1);
    end

    // Second pipeline stage: the captures from last cycle's edge are now in p0..p2.
    if (eval_q) begin
      case (state_q)
        StIdle: state_d = StSearch;
        StSearch: begin
          if (gap_det) begin
            state_d     = StSync;
            tooth_cnt_d = '0;
            gap_d       = 1'b1;
          end else begin
            period_d = p0_q;
          end
        end
        StSync: begin
          if (gap_det) begin
            tooth_cnt_d = '0;
            if (tooth_cnt_q == last_idx) begin
              gap_d = 1'b1;
            end else begin
              state_d = StSearch;
              err_d   = 1'b1;
            end
          end else begin
            tooth_cnt_d = tooth_cnt_q + TW'(1);
            period_d    = p0_q;
            if (tooth_cnt_q == last_idx) begin
              state_d = StSearch;
              err_d   = 1'b1;
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end

    if (sat_hit) begin
      stall_d = 1'b1;
      vcnt_d  = 2'd0;
      state_d = StIdle;
      gap_d   = 1'b0;
      err_d   = (state_q == StSync);
    end

    sync_d = (state_d == StSync);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      p0_q        <= '0;
      p1_q        <= '0;
      p2_q        <= '0;
      vcnt_q      <= 2'd0;
      eval_q      <= 1'b0;
      sync_q      <= 1'b0;
      tooth_cnt_q <= '0;
      period_q    <= '0;
      gap_q       <= 1'b0;
      err_q       <= 1'b0;
      stall_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      p0_q        <= p0_d;
      p1_q        <= p1_d;
      p2_q        <= p2_d;
      vcnt_q      <= vcnt_d;
      eval_q      <= eval_d;
      sync_q      <= sync_d;
      tooth_cnt_q <= tooth_cnt_d;
      period_q    <= period_d;
      gap_q       <= gap_d;
      err_q       <= err_d;
      stall_q     <= stall_d;
    end
  end

`ifdef HWAG_SYNC_ERRCNT_EN
  logic [7:0] err_cnt_q, err_cnt_d;

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (err_d && (err_cnt_q != 8'hFF)) err_cnt_d = err_cnt_q + 8'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_cnt_q <= 8'd0;
    else     err_cnt_q <= err_cnt_d;
  end

  assign err_cnt = err_cnt_q;
`else
  assign err_cnt = 8'd0;
`endif

  assign sync      = sync_q;
  assign tooth_cnt = tooth_cnt_q;
  assign period    = period_q;
  assign gap_pulse = gap_q;
  assign err_pulse = err_q;
  assign stall     = stall_q;

endmodule

// File: tb/tb_hwag_sync.sv
// Bench for hwag_sync: jittered wheel stimulus checked against an edge-level behavioural model.
// Phases: lock, early gap, filled gap, stall timeout, async reset, 36-3 wheel, error storm.
module tb_hwag_sync;
  localparam int PW   = 9;
  localparam int TW   = 8;
  localparam int MAXV = (1 << PW) - 1;
  localparam int NOM  = 50;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          tooth_edge = 1'b0;
  logic [TW-1:0] tooth_num = 8'd60;
  logic [1:0]    miss_num = 2'd2;
  logic          sync;
  logic [TW-1:0] tooth_cnt;
  logic [PW-1:0] period;
  logic          gap_pulse;
  logic          err_pulse;
  logic [7:0]    err_cnt;
  logic          stall;

  hwag_sync #(.PW(PW), .TW(TW)) dut (
    .clk(clk), .rst(rst), .tooth_edge(tooth_edge), .tooth_num(tooth_num),
    .miss_num(miss_num), .sync(sync), .tooth_cnt(tooth_cnt), .period(period),
    .gap_pulse(gap_pulse), .err_pulse(err_pulse), .err_cnt(err_cnt), .stall(stall)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;
  int cyc = 0, last_c = 0;
  int pos = 0;
  // Model: 0 idle, 1 search, 2 sync; captured periods newest first.
  int m_state, m_vcnt, m_tc, m_period, m_errcnt, m_errs = 0, m_gaps = 0;
  int m_p[3];
  int seen_gap = 0, seen_err = 0, both_seen = 0;

  always @(negedge clk) begin
    if (gap_pulse === 1'b1) seen_gap++;
    if (err_pulse === 1'b1) seen_err++;
    if (gap_pulse === 1'b1 && err_pulse === 1'b1) both_seen++;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  function automatic int exp_errcnt();
`ifdef HWAG_SYNC_ERRCNT_EN
    return (m_errcnt > 255) ? 255 : m_errcnt;
`else
    return 0;
`endif
  endfunction

  task automatic model_reset();
    m_state = 0; m_vcnt = 0; m_tc = 0; m_period = 0; m_errcnt = 0;
    m_p[0] = 0; m_p[1] = 0; m_p[2] = 0;
  endtask

  task automatic model_edge(input int delta, output bit eg, output bit ee);
    int  lst;
    bit  gap;
    eg  = 0;
    ee  = 0;
    lst = int'(tooth_num) - int'(miss_num) - 1;
    if (delta >= MAXV) begin
      // The counter timed out before this edge; this edge captures nothing.
      if (m_state == 2) begin m_errs++; m_errcnt++; end
      m_state = 0;
      m_vcnt  = 0;
    end else begin
      m_p[2] = m_p[1]; m_p[1] = m_p[0]; m_p[0] = delta;
      if (m_vcnt < 3) m_vcnt++;
    end
    gap = (m_vcnt == 3) && (m_p[0] > 2 * m_p[1]) && (m_p[0] > 2 * m_p[2]);
    if (m_state == 0) begin
      m_state = 1;
    end else if (m_state == 1) begin
      if (gap) begin m_state = 2; m_tc = 0; eg = 1; end
      else m_period = m_p[0];
    end else begin
      if (gap) begin
        if (m_tc == lst) eg = 1;
        else begin m_state = 1; ee = 1; end
        m_tc = 0;
      end else begin
        if (m_tc == lst) begin m_state = 1; ee = 1; end
        m_tc = (m_tc + 1) % 256;
        m_period = m_p[0];
      end
    end
    if (eg) m_gaps++;
    if (ee) begin m_errs++; m_errcnt++; end
  endtask

  // Emit one edge now, check its effects two clocks later, then idle until the next edge.
  task automatic tooth(input int ival);
    bit eg, ee;
    tooth_edge = 1'b1;
    model_edge(cyc - last_c, eg, ee);
    last_c = cyc;
    tick();
    tooth_edge = 1'b0;
    tick();
    chk("sync", sync, (m_state == 2));
    chk("tooth_cnt", tooth_cnt, m_tc);
    chk("period", period, m_period);
    chk("gap_pulse", gap_pulse, eg);
    chk("err_pulse", err_pulse, ee);
    chk("stall", stall, 0);
    chk("err_cnt", err_cnt, exp_errcnt());
    for (int k = 3; k <= ival; k++) begin
      tick();
      if (k == MAXV) begin
        chk("stall_set", stall, 1);
        chk("sync_timeout", sync, 0);
      end
    end
  endtask

  task automatic step1();
    int lst = int'(tooth_num) - int'(miss_num) - 1;
    if (pos == lst) begin
      pos = 0;
      tooth((int'(miss_num) + 1) * NOM + int'($urandom_range(0, 6)) - 3);
    end else begin
      pos++;
      tooth(NOM + int'($urandom_range(0, 4)) - 2);
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step1();
  endtask

  task automatic run_to(input int target);
    for (int i = 0; i < 256 && pos != target; i++) step1();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #2;
    chk("rst_sync", sync, 0);
    chk("rst_tooth_cnt", tooth_cnt, 0);
    chk("rst_period", period, 0);
    chk("rst_gap", gap_pulse, 0);
    chk("rst_err", err_pulse, 0);
    chk("rst_err_cnt", err_cnt, 0);
    chk("rst_stall", stall, 0);
    tick();
    tick();
    rst = 1'b0;
    model_reset();
    last_c = cyc;
  endtask

  initial begin
    bit found;
    model_reset();
    tick();
    do_reset();

    // 60-2 wheel lock and free running.
    pos = 0;
    run(130);
    chk("locked", sync, 1);

    // Two teeth lost around tooth 30: early gap.
    run_to(30);
    tooth(3 * NOM);
    pos = 33;
    run(75);

    // Gap filled by two extra teeth.
    run_to(int'(tooth_num) - int'(miss_num) - 1);
    tooth(NOM); tooth(NOM); tooth(NOM);
    pos = 0;
    run(75);

    // Wheel stops long enough to saturate the period counter.
    tooth(MAXV + 90);
    run(75);

    // Asynchronous reset while locked at tooth 20.
    found = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      if (m_state == 2 && m_tc == 20) found = 1;
      else step1();
    end
    chk("reached_tc20", found, 1);
    chk("pre_rst_tooth_cnt", tooth_cnt, 20);
    do_reset();
    run(75);

    // 36-3 wheel; configuration only changes while unsynchronised.
    do_reset();
    tooth_num = 8'd36;
    miss_num  = 2'd3;
    pos = 0;
    run(75);

    // Error storm: short gaps alternate between locking and early-gap loss.
    do_reset();
    tooth_num = 8'd60;
    miss_num  = 2'd2;
    for (int i = 0; i < 610; i++) begin
      tooth(3); tooth(3); tooth(9);
    end
    tick(); tick();
    chk("storm_err_cnt", err_cnt, exp_errcnt());
    chk("gap_total", seen_gap, m_gaps);
    chk("err_total", seen_err, m_errs);
    chk("pulse_overlap", both_seen, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
